// File: rtl/pipe_hazard_ctrl_t.sv
// Hazard/stall generator for the dual-lane pipeline: MEM wait > multi-cycle EX > redirect > load-use.
// Optional HAZARD_PERF_EN adds free-running stall-cycle and flush counters.
module pipe_hazard_ctrl_t #(
  parameter int MC_LAT_W   = 4,
  parameter int MEM_TO_CYC = 255
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                id_lu_hazard,
  input  logic                ex_redirect,
  input  logic                ex_mc_start,
  input  logic [MC_LAT_W-1:0] ex_mc_lat,
  input  logic                me_req_valid,
  input  logic                dmem_ready,
  output logic                s_if_stall_Q,
  output logic                s_id1_stall_Q,
  output logic                s_id2_stall_Q,
  output logic                s_ex1_stall_Q,
  output logic                s_ex2_stall_Q,
  output logic                s_me1_stall_Q,
  output logic                s_me2_stall_Q,
  output logic                s_wb1_stall_Q,
  output logic                s_wb2_stall_Q,
  output logic                s_id_clear_Q,
  output logic                s_ex1_clear_Q,
  output logic                s_ex2_clear_Q,
  output logic                s_me1_clear_Q,
  output logic                s_me2_clear_Q,
  output logic                s_wb1_clear_Q,
  output logic                s_wb2_clear_Q,
  output logic                hz_busy,
  output logic                mem_timeout,
  output logic [31:0]         perf_stall_cyc,
  output logic [31:0]         perf_flush_cnt
);

  typedef enum logic [1:0] {RUN, MCYC, MEMW} state_e;

  state_e              state_q, state_d;
  logic [MC_LAT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [7:0]          to_cnt_q, to_cnt_d;
  logic                redir_pend_q, redir_pend_d;
  logic                mem_timeout_q, mem_timeout_d;

  logic mem_stall, mc_go, mc_stall, any_stall, redir_apply, lu_stall;

  // Event decode shared by next-state and output logic, in priority order.
  always_comb begin
    mem_stall   = me_req_valid & ~dmem_ready;
    mc_go       = (state_q == RUN) & ex_mc_start & (ex_mc_lat >= MC_LAT_W'(2));
    mc_stall    = ~mem_stall & ((state_q == MCYC) | mc_go);
    any_stall   = mem_stall | mc_stall;
    redir_apply = ~any_stall & (ex_redirect | redir_pend_q);
    lu_stall    = ~any_stall & ~redir_apply & id_lu_hazard;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= RUN;
      mc_cnt_q      <= '0;
      to_cnt_q      <= '0;
      redir_pend_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mc_cnt_q      <= mc_cnt_d;
      to_cnt_q      <= to_cnt_d;
      redir_pend_q  <= redir_pend_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mc_cnt_d      = mc_cnt_q;
    to_cnt_d      = '0;
    mem_timeout_d = mem_timeout_q;
    redir_pend_d  = any_stall & (redir_pend_q | ex_redirect);
    if (mem_stall) begin
      // mc_cnt stays frozen so an interrupted multi-cycle op resumes afterwards.
      state_d  = MEMW;
      to_cnt_d = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
      if (to_cnt_d >= 8'(MEM_TO_CYC)) mem_timeout_d = 1'b1;
    end else begin
      case (state_q)
        RUN: if (mc_go) begin
          mc_cnt_d = ex_mc_lat - MC_LAT_W'(2);
          if (ex_mc_lat >= MC_LAT_W'(3)) state_d = MCYC;
        end
        MCYC: begin
          mc_cnt_d = mc_cnt_q - MC_LAT_W'(1);
          if (mc_cnt_q <= MC_LAT_W'(1)) begin
            state_d  = RUN;
            mc_cnt_d = '0;
          end
        end
        MEMW:    state_d = (mc_cnt_q != '0) ? MCYC : RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Mealy outputs; held low while reset is asserted even if inputs toggle.
  always_comb begin
    s_if_stall_Q  = 1'b0; s_id1_stall_Q = 1'b0; s_id2_stall_Q = 1'b0;
    s_ex1_stall_Q = 1'b0; s_ex2_stall_Q = 1'b0;
    s_me1_stall_Q = 1'b0; s_me2_stall_Q = 1'b0;
    s_wb1_stall_Q = 1'b0; s_wb2_stall_Q = 1'b0;
    s_id_clear_Q  = 1'b0;
    s_ex1_clear_Q = 1'b0; s_ex2_clear_Q = 1'b0;
    s_me1_clear_Q = 1'b0; s_me2_clear_Q = 1'b0;
    s_wb1_clear_Q = 1'b0; s_wb2_clear_Q = 1'b0;
    if (RST_N) begin
      if (mem_stall) begin
        {s_if_stall_Q, s_id1_stall_Q, s_id2_stall_Q} = 3'b111;
        {s_ex1_stall_Q, s_ex2_stall_Q, s_me1_stall_Q, s_me2_stall_Q} = 4'b1111;
        {s_wb1_clear_Q, s_wb2_clear_Q} = 2'b11;
      end else if (mc_stall) begin
        {s_if_stall_Q, s_id1_stall_Q, s_id2_stall_Q} = 3'b111;
        {s_ex1_stall_Q, s_ex2_stall_Q} = 2'b11;
        {s_me1_clear_Q, s_me2_clear_Q} = 2'b11;
      end else if (redir_apply) begin
        s_id_clear_Q = 1'b1;
      end else if (lu_stall) begin
        {s_if_stall_Q, s_id1_stall_Q, s_id2_stall_Q} = 3'b111;
        {s_ex1_clear_Q, s_ex2_clear_Q} = 2'b11;
      end
    end
  end

  assign hz_busy     = (state_q != RUN);
  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (s_if_stall_Q) perf_stall_q <= perf_stall_q + 32'd1;
      if (redir_apply)  perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cyc = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cyc = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule
